// File: rtl/shift_register_bank_if.sv
// shift_register_bank_if
// Groups the operation controls and data outputs of shift_register_bank.
//   master : drives clr/shift/ld/addr/dataIn and observes the bank outputs
//   slave  : the bank itself
// Signals:
//   clr, shift, ld  operation requests (priority clr > shift > ld)
//   addr   [AW]     entry index for ld
//   dataIn [SIZE]   write/shift data
//   dataOut[SIZE]   oldest entry (DEPTH-1)
//   dataAll[SIZE*DEPTH] all entries, entry i at [i*SIZE +: SIZE]
//   count  [CW]     valid entries from shifts, saturating at DEPTH
//   full            count == DEPTH
interface shift_register_bank_if #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 28
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  clr;
  logic                  shift;
  logic                  ld;
  logic [AW-1:0]         addr;
  logic [SIZE-1:0]       dataIn;
  logic [SIZE-1:0]       dataOut;
  logic [SIZE*DEPTH-1:0] dataAll;
  logic [CW-1:0]         count;
  logic                  full;

  modport master (
    output clr, shift, ld, addr, dataIn,
    input  dataOut, dataAll, count, full
  );

  modport slave (
    input  clr, shift, ld, addr, dataIn,
    output dataOut, dataAll, count, full
  );
endinterface

// File: rtl/shift_register_bank.sv
// shift_register_bank
// Bank of DEPTH entries of SIZE bits acting as a delay line / line buffer
// (shift-in at entry 0) with an addressed single-entry load, plus a
// saturating fill counter and a full flag.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-low
//   bus  shift_register_bank_if.slave (controls in, data/count/full out)
// All outputs come straight from registers.
module shift_register_bank #(
  parameter int SIZE  = 32,
  parameter int DEPTH = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_register_bank_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [AW:0]   DEPTH_A = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0][SIZE-1:0] entries_q, entries_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       full_q, full_d;
  logic                       addrOk;

  // When DEPTH is not a power of two the address can point past the bank;
  // such loads are silently dropped.
  assign addrOk = ({1'b0, bus.addr} < DEPTH_A);

  // Next-state logic. clr beats shift beats ld, and a shift drops any
  // simultaneous load completely. dataIn is only looked at when an
  // operation is actually taken, so X on it while idle cannot leak in.
  always_comb begin
    entries_d = entries_q;
    count_d   = count_q;
    if (bus.clr) begin
      entries_d = '0;
      count_d   = '0;
    end else if (bus.shift) begin
      entries_d[0] = bus.dataIn;
      for (int i = 1; i < DEPTH; i++) begin
        entries_d[i] = entries_q[i-1];
      end
      if (count_q != DEPTH_C) begin
        count_d = count_q + CW'(1);
      end
    end else if (bus.ld && addrOk) begin
      entries_d[bus.addr] = bus.dataIn;
    end
    // Registering full alongside count keeps it in step with the
    // registered count while keeping the output free of logic.
    full_d = (count_d == DEPTH_C);
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      entries_q <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
      full_q    <= full_d;
    end
  end

  assign bus.dataOut = entries_q[DEPTH-1];
  assign bus.dataAll = entries_q;
  assign bus.count   = count_q;
  assign bus.full    = full_q;
endmodule

// File: doc/shift_register_bank.md
Name: shift_register_bank

Overview:
- Parametrised successor to the single load/clear register.
- Holds DEPTH entries of SIZE bits, with three operations: clear, shift-in (delay line / line buffer) and addressed single-entry load.
- Tracks fill level and flags when the whole bank holds valid data.
- Used as the row buffer feeding the convolution window and as the staging store for weight and bias words.

Parameters:
SIZE, 32, bit width of each entry
DEPTH, 28, number of entries (DEPTH >= 2)
AW, $clog2(DEPTH), address width (derived; not to be overridden)
CW, $clog2(DEPTH+1), fill-count width (derived)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-low
clr  input  1  synchronous clear of all entries and count
shift  input  1  shift dataIn into entry 0; entry i moves to i+1; entry DEPTH-1 is discarded
ld  input  1  write dataIn into entry addr
addr  input  AW  entry index for ld
dataIn  input  SIZE  write/shift data
dataOut  output  SIZE  entry DEPTH-1 (oldest shifted word)
dataAll  output  SIZE*DEPTH  all entries flattened; entry i at bits [i*SIZE +: SIZE]
count  output  CW  number of valid entries from shifts, saturating at DEPTH
full  output  1  high when count == DEPTH

Behaviour:
- All state updates on the rising clk edge only; no asynchronous paths.
- rst sampled low at an edge: all entries = 0, count = 0, full = 0. Reset outputs: dataOut = 0, dataAll = 0.
- Priority per cycle: rst (low) > clr > shift > ld.
- clr: all entries = 0, count = 0, full = 0. shift and ld ignored that cycle.
- shift (clr low):
  - entry0 <= dataIn; entry[i] <= entry[i-1] for i = 1..DEPTH-1.
  - count <= min(count+1, DEPTH).
- ld (clr low, shift low):
  - addr < DEPTH: entry[addr] <= dataIn; all other entries hold.
  - addr >= DEPTH (possible when DEPTH is not a power of 2): no write; no error flag.
  - count unchanged.
- shift and ld both high: shift executes, ld is dropped entirely (no addressed write after the shift).
- No operation: all state holds.
- Latency: every operation is visible on dataOut/dataAll/count/full in the cycle after the edge. All outputs are driven directly from registers; no combinational path from inputs to outputs.
- full is derived from the registered count, so it rises the cycle after the DEPTH-th shift.
- Once count = DEPTH, further shifts keep count = DEPTH and full = 1 while data keeps flowing.
- Reset mid-fill (rst low at any count) returns the block to empty. A fill after reset starts from count 0.
- dataIn is sampled only on edges where an operation is taken.
- X on dataIn when no operation is taken must not propagate into state.

Test Plan (SIZE=8, DEPTH=4 unless noted):
1. Hold rst low 2 cycles, with shift=1 and clr=1 also driven -> dataAll=0, count=0, full=0. Release rst -> outputs stay 0.
2. Shift 0x11,0x22,0x33,0x44 on consecutive cycles:
   - after the 4th edge: dataAll={0x11,0x22,0x33,0x44} (entry3..entry0), dataOut=0x11, count=4, full=1.
   - shift 0x55 -> dataOut=0x22, count remains 4.
3. Simultaneous events:
   - shift=1, ld=1, addr=2, dataIn=0xAA -> only the shift occurs (entry0=0xAA, entry2 = old entry1).
   - clr=1 with shift=1 -> all 0, count=0.
4. ld with addr=3, dataIn=0x5A, shift=0 -> entry3=0x5A, dataOut=0x5A, count unchanged.
   - DEPTH=5 build: ld with addr=6 -> no entry changes.
5. Mid-fill reset: shift 2 words (count=2), drive rst low one cycle -> all 0, count=0. Refill needs 4 shifts before full=1.
6. Random mix of clr/shift/ld/idle for 2000 cycles against a reference model -> dataAll, count and full match every cycle. Repeat with SIZE=16, DEPTH=28.
